// File: rtl/seven_seg_scan_if.sv
// Application-side bundle for the seven-segment scanner: digit data and
// display controls in, board anode/segment pins and frame marker out.
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS  = 4,
  parameter int BRIGHT_BITS = 4
);
  logic [4*NUM_DIGITS-1:0] i_Digits;
  logic [NUM_DIGITS-1:0]   i_Dp;
  logic [NUM_DIGITS-1:0]   i_Blank;
  logic                    i_Lz_En;
  logic [BRIGHT_BITS-1:0]  i_Brightness;
  logic [NUM_DIGITS-1:0]   o_Anode;
  logic [7:0]              o_Segment;
  logic                    o_Frame_Start;

  modport master (
    output i_Digits, i_Dp, i_Blank, i_Lz_En, i_Brightness,
    input  o_Anode, o_Segment, o_Frame_Start
  );

  modport slave (
    input  i_Digits, i_Dp, i_Blank, i_Lz_En, i_Brightness,
    output o_Anode, o_Segment, o_Frame_Start
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with leading-zero
// suppression, PWM brightness with dead time and per-frame shadow latching.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_HZ      = 100_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int BRIGHT_BITS = 4,
  parameter int DEAD_CYCLES = 2
) (
  input logic         i_Clk,
  input logic         i_Rst_n,
  seven_seg_scan_if.slave bus
);
  localparam int SLOT_CYCLES = CLK_HZ / REFRESH_HZ;
  localparam int SUB_CYCLES  = SLOT_CYCLES >> BRIGHT_BITS;
  localparam int SLOT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int DIG_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] DEAD      = SLOT_W'(DEAD_CYCLES);
  localparam logic [SLOT_W-1:0] SUB_LEN   = SLOT_W'(SUB_CYCLES);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  if (CLK_HZ % REFRESH_HZ != 0) begin : g_chk_slot_int
    $error("CLK_HZ / REFRESH_HZ must be an integer");
  end
  if (SLOT_CYCLES % (1 << BRIGHT_BITS) != 0) begin : g_chk_slot_div
    $error("slot length must be a multiple of 2**BRIGHT_BITS");
  end
  if (DEAD_CYCLES >= SLOT_CYCLES) begin : g_chk_dead
    $error("DEAD_CYCLES must be shorter than the slot");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_chk_digits
    $error("NUM_DIGITS must be in 1..16");
  end

  logic [SLOT_W-1:0]       slot_cnt_reg, slot_cnt_next;
  logic [DIG_W-1:0]        digit_idx_reg, digit_idx_next;
  logic [4*NUM_DIGITS-1:0] digits_sh_reg;
  logic [NUM_DIGITS-1:0]   dp_sh_reg, blank_sh_reg;
  logic                    lz_sh_reg;
  logic [BRIGHT_BITS-1:0]  bright_reg;
  logic [NUM_DIGITS-1:0]   anode_reg, anode_next;
  logic [7:0]              segment_reg, segment_next;
  logic                    frame_start_reg;

  logic                    frame_start, slot_wrap, on_win;
  logic [BRIGHT_BITS-1:0]  sub_idx;
  logic [4*NUM_DIGITS-1:0] digits_eff;
  logic [NUM_DIGITS-1:0]   dp_eff, blank_eff, dig_zero, suppress, anode_sel;
  logic                    lz_eff, lead;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank, cur_sup;
  logic [6:0]              enc7;

  assign frame_start = (slot_cnt_reg == '0) && (digit_idx_reg == '0);
  assign slot_wrap   = (slot_cnt_reg == SLOT_LAST);
  assign sub_idx     = BRIGHT_BITS'(slot_cnt_reg / SUB_LEN);
  assign on_win      = (slot_cnt_reg >= DEAD) && (sub_idx <= bright_reg);

  always_comb begin
    slot_cnt_next  = slot_wrap ? '0 : slot_cnt_reg + SLOT_W'(1);
    digit_idx_next = digit_idx_reg;
    if (slot_wrap) begin
      digit_idx_next = (digit_idx_reg == DIG_LAST) ? '0 : digit_idx_reg + DIG_W'(1);
    end
  end

  // On the latch cycle itself, display the incoming data so the first slot
  // of a frame never shows the previous frame's digits.
  assign digits_eff = frame_start ? bus.i_Digits : digits_sh_reg;
  assign dp_eff     = frame_start ? bus.i_Dp     : dp_sh_reg;
  assign blank_eff  = frame_start ? bus.i_Blank  : blank_sh_reg;
  assign lz_eff     = frame_start ? bus.i_Lz_En  : lz_sh_reg;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_zero
    assign dig_zero[gi] = blank_eff[gi] | (digits_eff[4*gi +: 4] == 4'h0);
  end

  // Walk down from the most significant digit; digit 0 is always shown.
  always_comb begin
    suppress = '0;
    lead     = lz_eff;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead        = lead & dig_zero[i];
      suppress[i] = lead;
    end
  end

  assign cur_nib   = digits_eff[{digit_idx_reg, 2'b00} +: 4];
  assign cur_dp    = dp_eff[digit_idx_reg];
  assign cur_blank = blank_eff[digit_idx_reg];
  assign cur_sup   = suppress[digit_idx_reg];
  assign anode_sel = ~(NUM_DIGITS'(1) << digit_idx_reg);

  always_comb begin
    case (cur_nib)
      4'h0: enc7 = 7'h40;
      4'h1: enc7 = 7'h79;
      4'h2: enc7 = 7'h24;
      4'h3: enc7 = 7'h30;
      4'h4: enc7 = 7'h19;
      4'h5: enc7 = 7'h12;
      4'h6: enc7 = 7'h02;
      4'h7: enc7 = 7'h78;
      4'h8: enc7 = 7'h00;
      4'h9: enc7 = 7'h10;
      4'hA: enc7 = 7'h08;
      4'hB: enc7 = 7'h03;
      4'hC: enc7 = 7'h46;
      4'hD: enc7 = 7'h21;
      4'hE: enc7 = 7'h06;
      default: enc7 = 7'h0E;
    endcase
  end

  always_comb begin
    anode_next   = '1;
    segment_next = 8'hFF;
    if (on_win && !cur_blank) begin
      if (cur_sup) begin
        if (cur_dp) begin
          anode_next   = anode_sel;
          segment_next = 8'h7F;
        end
      end else begin
        anode_next   = anode_sel;
        segment_next = {~cur_dp, enc7};
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      slot_cnt_reg    <= '0;
      digit_idx_reg   <= '0;
      digits_sh_reg   <= '0;
      dp_sh_reg       <= '0;
      blank_sh_reg    <= '0;
      lz_sh_reg       <= 1'b0;
      bright_reg      <= '0;
      anode_reg       <= '1;
      segment_reg     <= 8'hFF;
      frame_start_reg <= 1'b0;
    end else begin
      slot_cnt_reg    <= slot_cnt_next;
      digit_idx_reg   <= digit_idx_next;
      anode_reg       <= anode_next;
      segment_reg     <= segment_next;
      frame_start_reg <= frame_start;
      if (frame_start) begin
        digits_sh_reg <= bus.i_Digits;
        dp_sh_reg     <= bus.i_Dp;
        blank_sh_reg  <= bus.i_Blank;
        lz_sh_reg     <= bus.i_Lz_En;
      end
      if (slot_cnt_reg == '0) begin
        bright_reg <= bus.i_Brightness;
      end
    end
  end

  assign bus.o_Anode       = anode_reg;
  assign bus.o_Segment     = segment_reg;
  assign bus.o_Frame_Start = frame_start_reg;
endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised N-digit time-multiplexed seven-segment display driver for the 100 MHz board designs. Each digit slot is scanned in turn on common-anode hardware with active-low anodes and segments. The driver adds four features: per-digit decimal point and blanking, leading-zero suppression, PWM brightness with anti-ghosting dead time, and tear-free shadow-latching of digit data once per frame. It sits between application logic and the board's anode/segment pins.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal range 1..16.
- CLK_HZ, 100_000_000, i_Clk frequency in Hz.
- REFRESH_HZ, 1000, slot rate in Hz; SLOT_CYCLES = CLK_HZ/REFRESH_HZ.
- BRIGHT_BITS, 4, brightness resolution; slot is split into 2^BRIGHT_BITS sub-periods.
- DEAD_CYCLES, 2, cycles at the start of each slot with all anodes off.
- i_Clk  in  1  system clock; all logic is on the rising edge.
- i_Rst_n  in  1  reset; asynchronous assert, active-low; deasserted synchronously by the board's reset logic.
- i_Digits  in  4*NUM_DIGITS  hex nibbles; [3:0] is digit 0 (least significant, rightmost).
- i_Dp  in  NUM_DIGITS  decimal point enable per digit.
- i_Blank  in  NUM_DIGITS  force a digit fully dark, including its DP.
- i_Lz_En  in  1  leading-zero suppression enable.
- i_Brightness  in  BRIGHT_BITS  0 = 1/2^B on-time, max = full on-time.
- o_Anode  out  NUM_DIGITS  active-low digit select.
- o_Segment  out  8  active-low; [6:0] = g,f,e,d,c,b,a; [7] = DP.
- o_Frame_Start  out  1  one-cycle pulse when the scan returns to digit 0.

## Operation
- Elaboration checks, each an error if violated:
  - SLOT_CYCLES is an integer.
  - SLOT_CYCLES is a multiple of 2^BRIGHT_BITS.
  - DEAD_CYCLES < SLOT_CYCLES.
  - NUM_DIGITS is in 1..16.
- Counters:
  - slot_cnt runs 0..SLOT_CYCLES-1 and wraps.
  - sub_idx = slot_cnt / (SLOT_CYCLES >> BRIGHT_BITS).
  - digit_idx increments when slot_cnt wraps, and wraps from NUM_DIGITS-1 to 0.
  - digit_idx width is max(1, clog2(NUM_DIGITS)).
- Frame start is the cycle where slot_cnt==0 and digit_idx==0. On that cycle:
  - i_Digits, i_Dp, i_Blank and i_Lz_En are latched into shadow registers.
  - o_Frame_Start pulses.
- i_Brightness is latched at every slot start (slot_cnt==0).
- On-window: the anode is enabled when slot_cnt >= DEAD_CYCLES and sub_idx <= latched brightness.
- Encoding is hex 0-F, active-low, DP off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - DP on clears bit 7.
- Leading-zero suppression applies when shadow i_Lz_En=1:
  - Scanning from digit NUM_DIGITS-1 downward, digits equal to 0 are suppressed until the first nonzero digit.
  - Digit 0 is never suppressed.
  - Digits with shadow i_Blank set count as zero for the suppression chain.
- Per-digit output when the anode is in its on-window:
  - Blanked digit: anode high, o_Segment=8'hFF.
  - LZ-suppressed digit with DP set: anode low, o_Segment=8'h7F.
  - LZ-suppressed digit without DP: anode high, o_Segment=8'hFF.
  - Otherwise: anode low, o_Segment = encoding with DP applied.
- Outside the on-window: o_Anode all ones, o_Segment=8'hFF.
- Active anode pattern is ~(1<<digit_idx); at most one anode is low in any cycle.

## Timing
- All outputs are registered and reflect counter state from the previous cycle (1-cycle latency).
- o_Frame_Start is high in the cycle after the frame-start counter state.
- Reset values:
  - o_Anode = all ones, o_Segment = 8'hFF, o_Frame_Start = 0.
  - Counters and shadow registers clear to 0.
  - Outputs take these values immediately on assertion, including mid-slot.
- The first frame starts on the first edge after reset release; the first o_Frame_Start is on the second edge.
- Frame period is NUM_DIGITS*SLOT_CYCLES cycles.
- Input changes mid-frame have no visible effect until the next frame start.
- Brightness changes take effect from the next slot.
- On-time per slot is (brightness+1)*SLOT_CYCLES/2^B - DEAD_CYCLES cycles, floored at 0.

## Test plan
Bench parameters: NUM_DIGITS=4, CLK_HZ=1600, REFRESH_HZ=100 (SLOT_CYCLES=16, one cycle per sub-period), BRIGHT_BITS=4, DEAD_CYCLES=2.
1. Reset: hold i_Rst_n low -> o_Anode=4'hF, o_Segment=8'hFF. Assert reset asynchronously mid-slot -> both return to reset values before the next edge. Release -> first o_Frame_Start on the second edge.
2. Scan and encoding: i_Digits=16'h1234, brightness=15 -> each slot shows 14 active cycles after 2 dead cycles, in this order:
   - 4'hE / 8'h99
   - 4'hD / 8'hB0
   - 4'hB / 8'hA4
   - 4'h7 / 8'hF9
   - o_Frame_Start pulses every 64 cycles.
3. Brightness:
   - brightness=3 -> 2 active cycles per slot (slot_cnt 2..3).
   - brightness=7 -> 6 active cycles.
   - brightness=0 -> anodes never low.
   - A change mid-slot applies from the next slot.
4. Leading zeros, with i_Lz_En=1:
   - 16'h0050 -> digits 3 and 2 dark; digit 1 shows 8'h92, digit 0 shows 8'hC0.
   - 16'h0000 -> only digit 0 lit (8'hC0).
   - i_Dp=4'b1000 on 16'h0050 -> digit 3 anode low with 8'h7F.
5. Tear-free update: change i_Digits from 16'h1111 to 16'h2222 at cycle 20 of a frame -> all slots show 8'hF9 until the next o_Frame_Start, then 8'hA4.
6. DP and blank:
   - i_Dp=4'b0010 -> digit 1 segment bit 7 = 0.
   - i_Blank=4'b0100 -> o_Anode[2] stays high for the whole frame, including when i_Dp[2]=1.
